// File: rtl/arb2_4_pkg.sv
// Shared definitions for the two-requester round-robin arbiter: output-stage
// state encoding and the source codes carried on sel/out_src.
package arb2_4_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/arb2_4_mux2_4.sv
// Operand selector feeding the shared output register: sel = 0 picks a, 1 picks b.
module mux2_4 #(
  parameter int WIDTH = 4
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arb2_4.sv
// Two-requester round-robin arbiter driving a single registered output slot,
// with a wrapping count of accepted requester transfers.
module arb2_4
  import arb2_4_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [CNTW-1:0]  xfer_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             slot_open;
  logic             xfer;
  logic             out_fire;
  logic [WIDTH-1:0] mux_data;

  // Grants are purely combinational; a tie goes to the side prio names.
  always_comb begin
    slot_open = !out_valid || out_ready;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    if (!rst && slot_open) begin
      if (req_a && req_b) begin
        if (prio_q == SRC_A) gnt_a = 1'b1;
        else                 gnt_b = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
    if (gnt_b)      sel = SRC_B;
    else if (gnt_a) sel = SRC_A;
    else            sel = sel_q;
    xfer     = gnt_a || gnt_b;
    out_fire = out_valid && out_ready;
  end

  mux2_4 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(sel),
    .a  (data_a),
    .b  (data_b),
    .y  (mux_data)
  );

  always_comb begin
    sel_d      = sel;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    if (xfer) begin
      out_data_d = mux_data;
      out_src_d  = sel;
      prio_d     = ~sel;
      cnt_d      = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_src_q  <= SRC_A;
      sel_q      <= SRC_A;
      prio_q     <= SRC_A;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      sel_q      <= sel_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
    end
  end

  // A simultaneous transfer and drain keeps the slot full for back-to-back throughput.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (out_fire && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
  end

  assign out_data = out_data_q;
  assign out_src  = out_src_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_arb2_4.sv
// Directed bench for arb2_4: a vector table with hand-computed results plus
// a counter-wrap sequence.
module tb_arb2_4;

  typedef struct packed {
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic [3:0] data_a;
    logic [3:0] data_b;
    logic       out_ready;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_src;
    logic [7:0] xfer_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, out_ready;
  logic [3:0] data_a, data_b;
  logic       gnt_a, gnt_b, sel, out_valid, out_src;
  logic [3:0] out_data;
  logic [7:0] xfer_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  arb2_4 #(
    .WIDTH(4),
    .CNTW (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .data_a   (data_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src),
    .xfer_cnt (xfer_cnt)
  );

  function automatic vec_t mk(input logic r, input logic ra, input logic rb,
                              input logic [3:0] da, input logic [3:0] db, input logic rdy,
                              input logic ga, input logic gb, input logic s,
                              input logic ov, input logic [3:0] od, input logic os,
                              input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.req_a = ra; v.req_b = rb; v.data_a = da; v.data_b = db;
    v.out_ready = rdy; v.gnt_a = ga; v.gnt_b = gb; v.sel = s;
    v.out_valid = ov; v.out_data = od; v.out_src = os; v.xfer_cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ra, input logic rb,
                               input logic [3:0] da, input logic [3:0] db, input logic rdy);
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db; out_ready = rdy;
  endtask

  initial begin
    int bad_gnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    @(posedge clk); #1;

    //            rst ra rb  da    db   rdy  ga gb sel  ov  od   src cnt
    vecs.push_back(mk(1, 0, 0, 4'h0, 4'h0, 0,   0, 0, 0,   0, 4'h0, 0, 8'd0));
    vecs.push_back(mk(1, 1, 1, 4'h3, 4'h5, 1,   0, 0, 0,   0, 4'h0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 0, 4'h3, 4'h0, 1,   1, 0, 0,   1, 4'h3, 0, 8'd1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 1,   0, 0, 0,   0, 4'h3, 0, 8'd1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 1,   0, 0, 0,   0, 4'h3, 0, 8'd1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 4'h0, 1,   0, 0, 0,   0, 4'h0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 1, 4'h0, 4'hF, 1,   1, 0, 0,   1, 4'h0, 0, 8'd1));
    vecs.push_back(mk(0, 1, 1, 4'h0, 4'hF, 1,   0, 1, 1,   1, 4'hF, 1, 8'd2));
    vecs.push_back(mk(0, 1, 1, 4'h0, 4'hF, 1,   1, 0, 0,   1, 4'h0, 0, 8'd3));
    vecs.push_back(mk(0, 1, 1, 4'h0, 4'hF, 1,   0, 1, 1,   1, 4'hF, 1, 8'd4));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 1, 4'h0, 4'h5, 0, 0, 0, 1,   1, 4'hF, 1, 8'd4));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h5, 1,   0, 1, 1,   1, 4'h5, 1, 8'd5));
    vecs.push_back(mk(0, 1, 1, 4'h9, 4'h6, 0,   0, 0, 1,   1, 4'h5, 1, 8'd5));
    vecs.push_back(mk(0, 1, 1, 4'h9, 4'h6, 1,   1, 0, 0,   1, 4'h9, 0, 8'd6));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h6, 1,   0, 1, 1,   1, 4'h6, 1, 8'd7));
    vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 0,   0, 0, 1,   1, 4'h6, 1, 8'd7));
    vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 1,   0, 0, 1,   0, 4'h6, 1, 8'd7));
    vecs.push_back(mk(0, 1, 0, 4'hA, 4'h0, 1,   1, 0, 0,   1, 4'hA, 0, 8'd8));
    vecs.push_back(mk(1, 1, 1, 4'hA, 4'hC, 0,   0, 0, 0,   0, 4'h0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 1, 4'hA, 4'hC, 1,   1, 0, 0,   1, 4'hA, 0, 8'd1));
    vecs.push_back(mk(0, 1, 1, 4'hA, 4'hC, 1,   0, 1, 1,   1, 4'hC, 1, 8'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 1,   0, 0, 1,   0, 4'hC, 1, 8'd2));
    vecs.push_back(mk(0, 1, 0, 4'h7, 4'h0, 0,   1, 0, 0,   1, 4'h7, 0, 8'd3));
    vecs.push_back(mk(0, 0, 1, 4'h0, 4'h2, 0,   0, 0, 0,   1, 4'h7, 0, 8'd3));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req_a, vecs[i].req_b,
                    vecs[i].data_a, vecs[i].data_b, vecs[i].out_ready);
      #1;
      checkOutput("gnt_a", i, 32'(gnt_a), 32'(vecs[i].gnt_a));
      checkOutput("gnt_b", i, 32'(gnt_b), 32'(vecs[i].gnt_b));
      checkOutput("sel",   i, 32'(sel),   32'(vecs[i].sel));
      @(posedge clk); #1;
      checkOutput("out_valid", i, 32'(out_valid), 32'(vecs[i].out_valid));
      checkOutput("out_data",  i, 32'(out_data),  32'(vecs[i].out_data));
      checkOutput("out_src",   i, 32'(out_src),   32'(vecs[i].out_src));
      checkOutput("xfer_cnt",  i, 32'(xfer_cnt),  32'(vecs[i].xfer_cnt));
    end

    // Counter wrap: 255 back-to-back A transfers, then one more.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    bad_gnt = 0;
    for (int n = 0; n < 255; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'(n), 4'h0, 1'b1);
      #1;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0) bad_gnt++;
      @(posedge clk); #1;
    end
    checkOutput("wrap_grants",   1000, 32'(bad_gnt),  32'd0);
    checkOutput("wrap_cnt_255",  1000, 32'(xfer_cnt), 32'd255);
    checkOutput("wrap_data_255", 1000, 32'(out_data), 32'hE);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 1'b1);
    @(posedge clk); #1;
    checkOutput("wrap_cnt_0",  1001, 32'(xfer_cnt),  32'd0);
    checkOutput("wrap_valid",  1001, 32'(out_valid), 32'd1);
    checkOutput("wrap_data",   1001, 32'(out_data),  32'h5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arb2_4.md
ARB2_4 -- requirements
Module: arb2_4

Interface
REQ-001 Parameter WIDTH, default 4, data width of each requester and of the output.
REQ-002 Parameter CNTW, default 8, width of the transfer counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_a  input  1  requester A valid; held with data_a stable until gnt_a.
REQ-006 data_a  input  WIDTH  requester A operand.
REQ-007 req_b  input  1  requester B valid; held with data_b stable until gnt_b.
REQ-008 data_b  input  WIDTH  requester B operand.
REQ-009 gnt_a  output  1  combinational accept for A; transfer occurs at an edge where req_a and gnt_a are both high.
REQ-010 gnt_b  output  1  combinational accept for B; same rule.
REQ-011 sel  output  1  mux select driven to the datapath: 0 selects A, 1 selects B.
REQ-012 out_valid  output  1  registered; out_data holds a captured operand.
REQ-013 out_ready  input  1  consumer accepts out_data at an edge where out_valid and out_ready are both high.
REQ-014 out_data  output  WIDTH  registered shared-bus result.
REQ-015 out_src  output  1  registered; source of out_data (0 = A, 1 = B).
REQ-016 xfer_cnt  output  CNTW  registered count of accepted requester transfers.

Function
REQ-017 Accept slot open when (!out_valid || out_ready); otherwise gnt_a = gnt_b = 0.
REQ-018 Arbitration round-robin with one-bit pointer prio (0 = A favoured, 1 = B favoured).
REQ-019 Only req_a high, slot open: gnt_a = 1, sel = 0; only req_b high: gnt_b = 1, sel = 1.
REQ-020 Both high, slot open: grant goes to side named by prio; never both grants in one cycle.
REQ-021 On each transfer, prio SHALL become the opposite of the side just granted.
REQ-022 No request or slot closed: sel holds its last value; prio unchanged.
REQ-023 Latency: data granted in cycle n appears on out_data with out_valid = 1 from cycle n+1.
REQ-024 Transfer and output handshake in the same cycle: out_data/out_src replaced, out_valid stays 1 (throughput one per cycle).
REQ-025 Output handshake without transfer: out_valid falls to 0 next cycle; out_data holds.
REQ-026 out_valid high, out_ready low: out_data, out_src, out_valid hold unchanged.
REQ-027 xfer_cnt increments by 1 per transfer, wraps from 2^CNTW-1 to 0 without flag.
REQ-028 Two-state FSM: EMPTY (out_valid = 0) and FULL (out_valid = 1); EMPTY->FULL on transfer; FULL->EMPTY on output handshake without transfer; otherwise stay.

Reset
REQ-029 rst high at an edge: out_valid = 0, out_data = 0, out_src = 0, sel = 0, prio = 0, xfer_cnt = 0, state EMPTY.
REQ-030 During any cycle with rst high, gnt_a = gnt_b = 0; no transfer counted.
REQ-031 rst mid-operation discards held out_data; requests still high re-arbitrate from prio = 0 after release.

Structure
REQ-032 Shared package holds FSM state encoding (EMPTY, FULL) and source codes SRC_A = 0, SRC_B = 1.
REQ-033 Operand selection SHALL instantiate the existing mux2_4 sub-module driven by sel; arbiter logic stays in arb2_4.

Verification
REQ-034 Reset then only req_a, data_a = 0011, out_ready = 1 -> gnt_a one cycle, next cycle out_data = 0011, out_src = 0, xfer_cnt = 1.
REQ-035 req_a, req_b high continuously, data_a = 0000, data_b = 1111, out_ready = 1 -> grants alternate A,B,A,B; out_data 0000,1111,0000,1111.
REQ-036 out_ready = 0 with out_valid = 1, req_b high -> gnt_b = 0, out_data stable for 5 cycles; out_ready = 1 -> gnt_b same cycle, new data next cycle.
REQ-037 Preload xfer_cnt to 255 via 255 transfers (CNTW = 8), one more -> xfer_cnt = 0.
REQ-038 rst asserted while out_valid = 1 and both req high -> next cycle out_valid = 0, xfer_cnt = 0; after release first grant goes to A.
REQ-039 No requests, out_ready = 1 after one transfer -> out_valid 1 then 0, sel unchanged, xfer_cnt unchanged.
